id_ex_stage: RTL

- Decode/issue stage directly upstream of the ALU in the 32-bit MIPS pipeline.
- Decodes the instruction and reads a 32-entry register file with a writeback port.
- Selects ALU operands and opcode, detects load-use hazards, and holds the registered ID/EX pipeline register that the ALU samples on the next clock edge.

---
 rtl/id_ex_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// Decode/issue stage feeding the ALU: register file with write-through bypass,
// instruction decode, load-use stall detection and the registered ID/EX pipeline register.
module id_ex_stage #(
  parameter int DATA_W    = 32,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  input  logic [31:0]       pc_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] store_data,
  output logic [4:0]        dest_addr,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic [31:0]       branch_target
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_BEQ  = 3'b110;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;

  assign opcode = instr_in[31:26];
  assign rs     = instr_in[25:21];
  assign rt     = instr_in[20:16];
  assign rd     = instr_in[15:11];
  assign funct  = instr_in[5:0];
  assign imm    = instr_in[15:0];

  logic [DATA_W-1:0] imm_sext;
  logic [31:0]       branch_offset;

  assign imm_sext      = {{(DATA_W-16){imm[15]}}, imm};
  assign branch_offset = {{14{imm[15]}}, imm, 2'b00};

  // Register file is cleared by reset, so it lives in flops rather than block RAM.
  logic [DATA_W-1:0] rf_reg [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf_reg[wb_addr] <= wb_data;
    end
  end

  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  always_comb begin
    rs_data = rf_reg[rs];
    rt_data = rf_reg[rt];
    if (rs == 5'd0)                 rs_data = '0;
    else if (wb_en && wb_addr == rs) rs_data = wb_data;
    if (rt == 5'd0)                 rt_data = '0;
    else if (wb_en && wb_addr == rt) rt_data = wb_data;
  end

  logic [2:0]        dec_alu_op;
  logic [DATA_W-1:0] dec_op_b;
  logic [4:0]        dec_dest;
  logic              dec_writes;
  logic              dec_mem_read;
  logic              dec_mem_write;
  logic              dec_branch;
  logic              use_rs;
  logic              use_rt;

  always_comb begin
    dec_alu_op    = ALU_NONE;
    dec_op_b      = '0;
    dec_dest      = 5'd0;
    dec_writes    = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    use_rs        = 1'b0;
    use_rt        = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec_alu_op = ALU_ADD;
          FN_SUB:  dec_alu_op = ALU_SUB;
          FN_AND:  dec_alu_op = ALU_AND;
          FN_OR:   dec_alu_op = ALU_OR;
          default: dec_alu_op = ALU_NONE;
        endcase
        // Unknown funct retires as a nop with no register sources.
        if (dec_alu_op != ALU_NONE) begin
          dec_op_b   = rt_data;
          dec_dest   = rd;
          dec_writes = 1'b1;
          use_rs     = 1'b1;
          use_rt     = 1'b1;
        end
      end
      OP_ADDI, OP_LW: begin
        dec_alu_op   = ALU_ADD;
        dec_op_b     = imm_sext;
        dec_dest     = rt;
        dec_writes   = 1'b1;
        dec_mem_read = (opcode == OP_LW);
        use_rs       = 1'b1;
      end
      OP_SW: begin
        dec_alu_op    = ALU_ADD;
        dec_op_b      = imm_sext;
        dec_mem_write = 1'b1;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
      end
      OP_BEQ: begin
        dec_alu_op = ALU_BEQ;
        dec_op_b   = rt_data;
        dec_branch = 1'b1;
        use_rs     = 1'b1;
        use_rt     = 1'b1;
      end
      default: begin
        dec_alu_op = ALU_NONE;
      end
    endcase
  end

  logic load_use;
  logic load_bubble;

  assign load_use = ex_valid && mem_read && (dest_addr != 5'd0) && instr_valid &&
                    ((use_rs && (rs == dest_addr)) || (use_rt && (rt == dest_addr)));
  assign stall_out   = HAZARD_EN ? load_use : 1'b0;
  assign load_bubble = flush || !instr_valid || stall_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || load_bubble) begin
      ex_valid      <= 1'b0;
      op_a          <= '0;
      op_b          <= '0;
      alu_op        <= ALU_NONE;
      store_data    <= '0;
      dest_addr     <= 5'd0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      branch        <= 1'b0;
      branch_target <= 32'd0;
    end else begin
      ex_valid      <= 1'b1;
      op_a          <= rs_data;
      op_b          <= dec_op_b;
      alu_op        <= dec_alu_op;
      store_data    <= rt_data;
      dest_addr     <= dec_dest;
      reg_write     <= dec_writes && (dec_dest != 5'd0);
      mem_read      <= dec_mem_read;
      mem_write     <= dec_mem_write;
      branch        <= dec_branch;
      branch_target <= pc_in + 32'd4 + branch_offset;
    end
  end

endmodule
